// File: rtl/regfile_mp_sb.sv
// ---------------------------------------------------------------------------
// regfile_mp_sb -- parametrised multi-port integer register file with
// pending-write scoreboard.
//
// Holds NREGS registers of XLEN bits (register 0 hardwired to zero), serves
// NRD combinational read ports and accepts NWR write ports per cycle. A busy
// bit per register tracks an issued-but-not-written-back destination so the
// decode stage can detect RAW hazards directly from rbusy.
//
// Ports:
//   clk          rising-edge clock for all state
//   rst          synchronous active-high reset (loads reset image, clears busy)
//   we           per-port write enable            [NWR]
//   waddr        write indices, port p at [p*AW +: AW]
//   wdata        write data, port p at [p*XLEN +: XLEN]
//   raddr        read indices, port k at [k*AW +: AW]
//   rdata        read data (combinational), port k at [k*XLEN +: XLEN]
//   rbusy        busy flag of each read index (combinational)
//   issue_valid  an instruction with a destination issues this cycle
//   issue_rd     destination index of the issuing instruction
//   debug_addr   debug read index
//   debug_data   stored value at debug_addr, never bypassed
// ---------------------------------------------------------------------------
module regfile_mp_sb #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int BYPASS   = 1,
  parameter int INIT_IDX = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   waddr,
  input  logic [NWR*XLEN-1:0] wdata,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  input  logic                issue_valid,
  input  logic [AW-1:0]       issue_rd,
  input  logic [AW-1:0]       debug_addr,
  output logic [XLEN-1:0]     debug_data
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Scan all write ports for a hit on idx. Returns {hit, data}; ascending
  // scan means the highest-numbered matching port overrides lower ones,
  // which is the collision rule for both storage and bypass. Index 0 never
  // hits, so writes to x0 vanish everywhere.
  function automatic logic [XLEN:0] wr_lookup(
    input logic [AW-1:0]       idx,
    input logic [NWR-1:0]      we_v,
    input logic [NWR*AW-1:0]   wa_v,
    input logic [NWR*XLEN-1:0] wd_v
  );
    logic            hit;
    logic [XLEN-1:0] data;
    hit  = 1'b0;
    data = '0;
    for (int p = 0; p < NWR; p++) begin
      if (we_v[p] && (wa_v[p*AW +: AW] == idx) && (idx != '0)) begin
        hit  = 1'b1;
        data = wd_v[p*XLEN +: XLEN];
      end else begin
        hit  = hit;
        data = data;
      end
    end
    return {hit, data};
  endfunction

  // Next-state for register array and scoreboard (normal operation only).
  always_comb begin
    logic [XLEN:0] look;
    look      = '0;
    busy_d    = '0;
    regs_d[0] = '0;
    for (int i = 1; i < NREGS; i++) begin
      look = wr_lookup(AW'(i), we, waddr, wdata);
      if (look[XLEN]) begin
        regs_d[i] = look[XLEN-1:0];
      end else begin
        regs_d[i] = regs_q[i];
      end
      // A new producer issuing in the writeback cycle of the old one keeps
      // the register pending: set has priority over clear.
      if (issue_valid && (issue_rd == AW'(i))) begin
        busy_d[i] = 1'b1;
      end else if (look[XLEN]) begin
        busy_d[i] = 1'b0;
      end else begin
        busy_d[i] = busy_q[i];
      end
    end
  end

  // State update; reset loads the reset image and drops same-cycle writes/issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= ((INIT_IDX != 0) && (i != 0)) ? XLEN'(i) : '0;
      end
      busy_q <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      busy_q <= busy_d;
    end
  end

  // Read ports: x0 reads zero, optional same-cycle forwarding (off during
  // reset), otherwise the stored value and its busy bit.
  always_comb begin
    logic [AW-1:0] ridx;
    logic [XLEN:0] rlook;
    ridx  = '0;
    rlook = '0;
    rdata = '0;
    rbusy = '0;
    for (int k = 0; k < NRD; k++) begin
      ridx  = raddr[k*AW +: AW];
      rlook = wr_lookup(ridx, we, waddr, wdata);
      if (ridx == '0) begin
        rdata[k*XLEN +: XLEN] = '0;
        rbusy[k]              = 1'b0;
      end else if ((BYPASS != 0) && !rst && rlook[XLEN]) begin
        // The value being written back resolves the hazard this cycle.
        rdata[k*XLEN +: XLEN] = rlook[XLEN-1:0];
        rbusy[k]              = 1'b0;
      end else begin
        rdata[k*XLEN +: XLEN] = regs_q[ridx];
        rbusy[k]              = busy_q[ridx] && !rst;
      end
    end
  end

  // Debug port: stored value only, never forwarded.
  always_comb begin
    if (debug_addr == '0) begin
      debug_data = '0;
    end else begin
      debug_data = regs_q[debug_addr];
    end
  end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised multi-port integer register file, successor to the single-write/dual-read pipeline register file.
- Configurable read-port and write-port counts, and optional same-cycle write-to-read bypass.
- Selectable reset image and a per-register pending-write scoreboard (busy bits), so ID can detect RAW hazards without a separate unit.
- Sits between IF_ID/ID_EX (reads, issue) and MEM_WB plus other writeback sources (writes).

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of architectural registers (power of 2, >=2); AW = clog2(NREGS)
NRD, 2, number of read ports (1..4)
NWR, 1, number of write ports (1..3)
BYPASS, 1, 1 = read returns same-cycle write data; 0 = read returns stored value
INIT_IDX, 1, reset image: 1 = register i holds i; 0 = all zero

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
we  in  NWR  per-port write enable
waddr  in  NWR*AW  write indices, port p at [p*AW +: AW]
wdata  in  NWR*XLEN  write data, port p at [p*XLEN +: XLEN]
raddr  in  NRD*AW  read indices
rdata  out  NRD*XLEN  read data (combinational)
rbusy  out  NRD  scoreboard busy flag for each read index (combinational)
issue_valid  in  1  an instruction with a destination is issuing this cycle
issue_rd  in  AW  destination index of the issuing instruction
debug_addr  in  AW  debug read index
debug_data  out  XLEN  stored value of debug_addr, never bypassed

Behaviour:
- Reset (rst=1 at rising edge):
  - reg[i] <= (INIT_IDX ? i : 0); reg[0] is always 0 regardless of INIT_IDX.
  - All busy bits <= 0.
  - Writes and issue in that cycle are dropped.
  - While rst=1, bypass is disabled and rbusy is forced to 0.
- Outputs have no registered stage. rdata, rbusy and debug_data are pure functions of the state and the current inputs, so after a reset edge they reflect the reset image.
- Register 0 is hardwired to 0:
  - Writes with waddr=0 are ignored.
  - A read of index 0 always returns 0 and rbusy=0, including under bypass.
  - busy[0] is never set.
- Write, at the rising edge with rst=0: for each p with we[p]=1 and waddr[p]!=0, reg[waddr[p]] <= wdata[p].
- Same-address write collision (multiple ports, same nonzero index): the highest-numbered port wins, deterministically. No error flag.
- Read, BYPASS=1:
  - If any port p has we[p]=1 and waddr[p]==raddr[k]!=0, rdata[k] = wdata of the highest such p.
  - Otherwise rdata[k] = reg[raddr[k]].
  - This gives zero-cycle write-to-read forwarding, so the WB->ID hazard needs no external forward.
- Read, BYPASS=0: rdata[k] = reg[raddr[k]]. A same-cycle write becomes visible the next cycle.
- Scoreboard, per register i!=0, at each edge with rst=0:
  - set  = issue_valid && issue_rd==i
  - clr  = any we[p] && waddr[p]==i
  - busy[i] <= set ? 1 : (clr ? 0 : busy[i])
  - When set and clr occur together, set wins: the new producer supersedes the completing one.
- rbusy[k]:
  - rbusy[k] = busy[raddr[k]] && !(BYPASS && any write hits raddr[k] this cycle).
  - With BYPASS=0, rbusy stays asserted through the writeback cycle and drops the cycle after.
- Issue to index 0 is a no-op.
- Writing a register whose busy bit is clear is legal: data is updated and busy stays 0.
- No internal state besides the register array and the busy vector. Latency is 0 cycles for reads and 1 edge for writes and scoreboard updates.

Test Plan:
- Reset image: INIT_IDX=1, assert rst for 1 cycle, then sweep debug_addr 0..31 -> debug_data==i. Same with INIT_IDX=0 -> all 0, all rbusy=0.
- x0 protection: we[0]=1, waddr=0, wdata=32'hDEADBEEF, raddr[0]=0 in the same cycle and the next -> rdata[0]==0 both cycles. Issue to rd=0 -> rbusy never set.
- Bypass vs no bypass: write x5=32'h1234 while raddr[1]=5.
  - BYPASS=1 -> rdata[1]==32'h1234 in the same cycle.
  - BYPASS=0 -> old value (5) in the same cycle, 32'h1234 the next cycle.
- Write collision (NWR=2): both ports write x7, port0=32'hAAAA and port1=32'hBBBB -> same-cycle bypass read and next-cycle stored value are both 32'hBBBB.
- Scoreboard:
  - Issue rd=9 at cycle t -> rbusy for raddr=9 is 1 from t+1.
  - Write x9 at t+3 -> with BYPASS=1, rbusy=0 at t+3 and rdata=wdata.
  - Issue rd=9 plus write x9 in the same cycle -> busy stays 1 next cycle, data updated.
- Reset mid-operation: busy x3 set, assert rst coincident with a write of x3=32'h55 -> after the edge, reg[3]==3 (INIT_IDX=1), busy[3]==0, and rdata/rbusy during the rst cycle show no bypass and no busy.
